// File: rtl/shifter_pkg.sv
// Shared constants, op encoding and effective-amount helper for seq_shifter.
// ROR support is gated by macro SEQ_SHIFTER_ROTATE_EN.
package shifter_pkg;

  localparam int DATA_W = 64;
  localparam int CLAMP  = 64;
  localparam int AMT_W  = 7;

  typedef enum logic [1:0] {
    OP_SRL = 2'b00,
    OP_SLL = 2'b01,
    OP_SRA = 2'b10,
    OP_ROR = 2'b11
  } op_e;

  // Linear shifts saturate at CLAMP; rotates wrap modulo the width.
  function automatic logic [AMT_W-1:0] eff_amount(input logic [DATA_W-1:0] shamt,
                                                  input op_e op);
    logic [AMT_W-1:0] amt;
    if (op == OP_ROR) begin
`ifdef SEQ_SHIFTER_ROTATE_EN
      amt = {1'b0, shamt[5:0]};
`else
      amt = '0;
`endif
    end else if (shamt >= 64'(CLAMP)) begin
      amt = AMT_W'(CLAMP);
    end else begin
      amt = shamt[AMT_W-1:0];
    end
    return amt;
  endfunction

endpackage

// File: rtl/seq_shifter_shift_step.sv
// Combinational single-step shifter: moves value by 0..STEP positions.
// The rotate path exists only when SEQ_SHIFTER_ROTATE_EN is defined.
module shift_step
  import shifter_pkg::*;
#(
  parameter int STEP = 8,
  localparam int AW  = $clog2(STEP + 1)
) (
  input  logic [DATA_W-1:0] value,
  input  logic [AW-1:0]     amount,
  input  op_e               op,
  output logic [DATA_W-1:0] shifted
);

  always_comb begin
    shifted = value;
    case (op)
      OP_SRL: shifted = value >> amount;
      OP_SLL: shifted = value << amount;
      OP_SRA: shifted = DATA_W'($signed(value) >>> amount);
`ifdef SEQ_SHIFTER_ROTATE_EN
      // amount == 0 makes the left term shift by the full width, giving 0.
      OP_ROR: shifted = (value >> amount) | (value << (7'(DATA_W) - 7'(amount)));
`endif
      default: shifted = value;
    endcase
  end

endmodule

// File: rtl/seq_shifter.sv
// Multi-cycle shifter: shifts up to STEP bit positions per cycle, valid/ready on both sides.
// Rotate (op 11) is supported only when SEQ_SHIFTER_ROTATE_EN is defined.
module seq_shifter
  import shifter_pkg::*;
#(
  parameter int STEP = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_W-1:0]   operand,
  input  logic [DATA_W-1:0]   shamt,
  input  logic [1:0]          op,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_W-1:0]   result,
  output logic                busy
);

  localparam int AW = $clog2(STEP + 1);
  localparam logic [AMT_W-1:0] STEP_AMT = AMT_W'(STEP);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  logic [1:0]        state_reg;
  logic [DATA_W-1:0] value_reg;
  logic [AMT_W-1:0]  remaining_reg;
  op_e               op_reg;

  op_e               op_in;
  logic [AMT_W-1:0]  eff;
  logic [AMT_W-1:0]  step_full;
  logic [AW-1:0]     step_amt;
  logic [DATA_W-1:0] shifted;

  assign op_in     = op_e'(op);
  assign eff       = eff_amount(shamt, op_in);
  assign step_full = (remaining_reg >= STEP_AMT) ? STEP_AMT : remaining_reg;
  assign step_amt  = AW'(step_full);

  shift_step #(
    .STEP(STEP)
  ) u_shift_step (
    .value  (value_reg),
    .amount (step_amt),
    .op     (op_reg),
    .shifted(shifted)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= ST_IDLE;
      value_reg     <= '0;
      remaining_reg <= '0;
      op_reg        <= OP_SRL;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (in_valid) begin
            value_reg     <= operand;
            op_reg        <= op_in;
            remaining_reg <= eff;
            state_reg     <= (eff == '0) ? ST_DONE : ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          value_reg     <= shifted;
          remaining_reg <= remaining_reg - step_full;
          if (remaining_reg == step_full) state_reg <= ST_DONE;
        end
        ST_DONE: begin
          if (out_ready) state_reg <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = (state_reg == ST_IDLE);
  assign out_valid = (state_reg == ST_DONE);
  assign busy      = (state_reg != ST_IDLE);
  assign result    = value_reg;

endmodule
